// File: rtl/airlock_interlock_ctrl.sv
// Two-door airlock sequencer: PRESSED <-> EVACED through timed pump phases, with abort and fault latch.
// One-edge latency from key edge or door switch to registered outputs; no backpressure, requests are single-edge events.
module airlock_interlock_ctrl #(
  parameter int EVAC_CYCLES  = 8,
  parameter int PRESS_CYCLES = 5,
  parameter int CNT_W        = 4
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             EvacKey_n,
  input  logic             PressKey_n,
  input  logic             InnerOpenSw,
  input  logic             OuterOpenSw,
  output logic             InnerDoorEn,
  output logic             OuterDoorEn,
  output logic             Pressurized,
  output logic             Evacuated,
  output logic             Busy,
  output logic             Fault,
  output logic [2:0]       State,
  output logic [CNT_W-1:0] Countdown
);

  typedef enum logic [2:0] {
    S_PRESSED      = 3'd0,
    S_EVACUATING   = 3'd1,
    S_EVACED       = 3'd2,
    S_PRESSURIZING = 3'd3,
    S_FAULT        = 3'd4
  } state_t;

  localparam logic [CNT_W-1:0] EVAC_LOAD  = CNT_W'(EVAC_CYCLES - 1);
  localparam logic [CNT_W-1:0] PRESS_LOAD = CNT_W'(PRESS_CYCLES - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             evac_key_q, press_key_q;
  logic             evac_req, press_req;
  logic             door_open;

  // Simultaneous requests cancel each other out.
  assign evac_req  = evac_key_q & ~EvacKey_n & ~(press_key_q & ~PressKey_n);
  assign press_req = press_key_q & ~PressKey_n & ~(evac_key_q & ~EvacKey_n);
  assign door_open = InnerOpenSw | OuterOpenSw;

  always_comb begin
    state_d = state_q;
    cnt_d   = '0;
    case (state_q)
      S_PRESSED: begin
        if (OuterOpenSw) begin
          state_d = S_FAULT;
        end else if (evac_req && !door_open) begin
          state_d = S_EVACUATING;
          cnt_d   = EVAC_LOAD;
        end
      end
      S_EVACUATING: begin
        if (door_open) begin
          state_d = S_FAULT;
        end else if (press_req) begin
          state_d = S_PRESSURIZING;
          cnt_d   = PRESS_LOAD;
        end else if (cnt_q == '0) begin
          state_d = S_EVACED;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      S_EVACED: begin
        if (InnerOpenSw) begin
          state_d = S_FAULT;
        end else if (press_req && !door_open) begin
          state_d = S_PRESSURIZING;
          cnt_d   = PRESS_LOAD;
        end
      end
      S_PRESSURIZING: begin
        if (door_open) begin
          state_d = S_FAULT;
        end else if (evac_req) begin
          state_d = S_EVACUATING;
          cnt_d   = EVAC_LOAD;
        end else if (cnt_q == '0) begin
          state_d = S_PRESSED;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      S_FAULT: begin
        // Recovery only by pressurizing with the chamber sealed.
        if (press_req && !door_open) begin
          state_d = S_PRESSURIZING;
          cnt_d   = PRESS_LOAD;
        end
      end
      default: state_d = S_FAULT;
    endcase
  end

  // Status outputs are registered from the next state so they align with State.
  always_ff @(posedge Clock) begin
    if (!Reset) begin
      state_q     <= S_PRESSED;
      cnt_q       <= '0;
      evac_key_q  <= 1'b1;
      press_key_q <= 1'b1;
      InnerDoorEn <= 1'b1;
      OuterDoorEn <= 1'b0;
      Pressurized <= 1'b1;
      Evacuated   <= 1'b0;
      Busy        <= 1'b0;
      Fault       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      evac_key_q  <= EvacKey_n;
      press_key_q <= PressKey_n;
      InnerDoorEn <= (state_d == S_PRESSED);
      OuterDoorEn <= (state_d == S_EVACED);
      Pressurized <= (state_d == S_PRESSED);
      Evacuated   <= (state_d == S_EVACED);
      Busy        <= (state_d == S_EVACUATING) || (state_d == S_PRESSURIZING);
      Fault       <= (state_d == S_FAULT);
    end
  end

  assign State     = state_q;
  assign Countdown = cnt_q;

endmodule

// File: tb/tb_airlock_interlock_ctrl.sv
// Bench for airlock_interlock_ctrl: directed vector table followed by randomized traffic
// checked against a timestamp-based reference model.
module tb_airlock_interlock_ctrl;

  localparam int EVAC  = 8;
  localparam int PRESS = 5;
  localparam int CW    = 4;

  logic          Clock = 1'b0;
  logic          Reset = 1'b0;
  logic          EvacKey_n = 1'b1;
  logic          PressKey_n = 1'b1;
  logic          InnerOpenSw = 1'b0;
  logic          OuterOpenSw = 1'b0;
  logic          InnerDoorEn, OuterDoorEn, Pressurized, Evacuated, Busy, Fault;
  logic [2:0]    State;
  logic [CW-1:0] Countdown;

  airlock_interlock_ctrl #(.EVAC_CYCLES(EVAC), .PRESS_CYCLES(PRESS), .CNT_W(CW)) dut (
    .Clock(Clock), .Reset(Reset), .EvacKey_n(EvacKey_n), .PressKey_n(PressKey_n),
    .InnerOpenSw(InnerOpenSw), .OuterOpenSw(OuterOpenSw),
    .InnerDoorEn(InnerDoorEn), .OuterDoorEn(OuterDoorEn), .Pressurized(Pressurized),
    .Evacuated(Evacuated), .Busy(Busy), .Fault(Fault), .State(State), .Countdown(Countdown)
  );

  always #5 Clock = ~Clock;

  typedef struct {
    logic rst_n;
    logic ek;
    logic pk;
    logic isw;
    logic osw;
    int   st;
    int   cnt;
  } vec_t;

  vec_t vecs[$];
  int   checks   = 0;
  int   failures = 0;

  // {InnerDoorEn, OuterDoorEn, Pressurized, Evacuated, Busy, Fault}
  function automatic logic [5:0] flags_of(int st);
    return {st == 0, st == 2, st == 0, st == 2, (st == 1) || (st == 3), st == 4};
  endfunction

  task automatic check(string name, int st, int cnt);
    logic [5:0] got, exp;
    got = {InnerDoorEn, OuterDoorEn, Pressurized, Evacuated, Busy, Fault};
    exp = flags_of(st);
    checks++;
    if (State !== 3'(st) || Countdown !== CW'(cnt) || got !== exp) begin
      failures++;
      $display("FAIL %s: got state=%0d cnt=%0d flags=%b, want state=%0d cnt=%0d flags=%b",
               name, State, Countdown, got, st, cnt, exp);
    end
  endtask

  task automatic add(logic r, logic ek, logic pk, logic isw, logic osw, int st, int cnt);
    vec_t v;
    v.rst_n = r; v.ek = ek; v.pk = pk; v.isw = isw; v.osw = osw; v.st = st; v.cnt = cnt;
    vecs.push_back(v);
  endtask

  // Reference model: pump phases tracked by entry timestamp, not a down-counter.
  int   m_st, m_start, m_n;
  logic m_ekq, m_pkq;

  function automatic int model_cnt();
    if (m_st == 1) return EVAC - 1 - (m_n - m_start);
    if (m_st == 3) return PRESS - 1 - (m_n - m_start);
    return 0;
  endfunction

  task automatic model_step(logic r, logic ek, logic pk, logic isw, logic osw);
    logic er, pr, open;
    m_n++;
    if (!r) begin
      m_st = 0; m_ekq = 1'b1; m_pkq = 1'b1;
      return;
    end
    er   = m_ekq && !ek;
    pr   = m_pkq && !pk;
    if (er && pr) begin er = 1'b0; pr = 1'b0; end
    open = isw || osw;
    case (m_st)
      0: if (osw) m_st = 4; else if (er && !open) begin m_st = 1; m_start = m_n; end
      1: if (open) m_st = 4; else if (pr) begin m_st = 3; m_start = m_n; end
         else if (m_n - m_start == EVAC) m_st = 2;
      2: if (isw) m_st = 4; else if (pr && !open) begin m_st = 3; m_start = m_n; end
      3: if (open) m_st = 4; else if (er) begin m_st = 1; m_start = m_n; end
         else if (m_n - m_start == PRESS) m_st = 0;
      default: if (pr && !open) begin m_st = 3; m_start = m_n; end
    endcase
    m_ekq = ek; m_pkq = pk;
  endtask

  initial begin
    // reset and idle
    add(0,1,1,0,0, 0,0);
    add(0,1,1,0,0, 0,0);
    add(1,1,1,0,0, 0,0);
    // evacuate: entry then full countdown, EVACED exactly 8 edges after entry
    add(1,0,1,0,0, 1,7);
    for (int c = 6; c >= 0; c--) add(1,0,1,0,0, 1,c);
    add(1,0,1,0,0, 2,0);
    add(1,1,1,0,0, 2,0);
    // pressurize then abort two edges later
    add(1,1,0,0,0, 3,4);
    add(1,1,0,0,0, 3,3);
    add(1,0,0,0,0, 1,7);
    // inner door opens mid-evacuation, recover by pressurizing
    add(1,0,0,1,0, 4,0);
    add(1,1,1,0,0, 4,0);
    add(1,1,0,0,0, 3,4);
    for (int c = 3; c >= 0; c--) add(1,1,1,0,0, 3,c);
    add(1,1,1,0,0, 0,0);
    // simultaneous requests cancel; long key hold gives one request
    add(1,0,0,0,0, 0,0);
    add(1,1,1,0,0, 0,0);
    add(1,0,1,0,0, 1,7);
    for (int c = 6; c >= 0; c--) add(1,0,1,0,0, 1,c);
    add(1,0,1,0,0, 2,0);
    add(1,0,1,0,0, 2,0);
    // reset in the middle of pressurizing
    add(1,1,1,0,0, 2,0);
    add(1,1,0,0,0, 3,4);
    add(1,1,0,0,0, 3,3);
    add(0,1,0,0,0, 0,0);
    add(1,1,1,0,0, 0,0);
    // evac request with inner door open is ignored; outer door open in PRESSED faults
    add(1,0,1,1,0, 0,0);
    add(1,1,1,0,1, 4,0);
    add(1,0,1,0,0, 4,0);
    add(1,1,0,0,0, 3,4);

    for (int i = 0; i < vecs.size(); i++) begin
      Reset = vecs[i].rst_n; EvacKey_n = vecs[i].ek; PressKey_n = vecs[i].pk;
      InnerOpenSw = vecs[i].isw; OuterOpenSw = vecs[i].osw;
      @(posedge Clock); #1;
      check($sformatf("vec%0d", i), vecs[i].st, vecs[i].cnt);
    end

    // randomized run against the model
    m_n = 0; m_start = 0; m_st = 0; m_ekq = 1'b1; m_pkq = 1'b1;
    Reset = 1'b0; EvacKey_n = 1'b1; PressKey_n = 1'b1; InnerOpenSw = 1'b0; OuterOpenSw = 1'b0;
    @(posedge Clock); #1;
    model_step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    check("rand_reset", m_st, model_cnt());
    for (int i = 0; i < 4000; i++) begin
      Reset = ($urandom_range(0, 149) != 0);
      if ($urandom_range(0, 3) == 0) EvacKey_n = ~EvacKey_n;
      if ($urandom_range(0, 3) == 0) PressKey_n = ~PressKey_n;
      InnerOpenSw = ($urandom_range(0, 39) == 0);
      OuterOpenSw = ($urandom_range(0, 39) == 0);
      @(posedge Clock); #1;
      model_step(Reset, EvacKey_n, PressKey_n, InnerOpenSw, OuterOpenSw);
      check($sformatf("rand%0d", i), m_st, model_cnt());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
